// File: rtl/servo_ramp.sv
// Slew-rate limiter feeding the servo PWM width input: steps pos toward an
// accepted target by at most rate units per tick, with optional immediate jump.
//
// state  | meaning
// S_IDLE | pos holds at the last reached target
// S_RAMP | pos is being stepped toward r_tgt once per tick
module servo_ramp #(
    parameter int CLK_DIV  = 100000,
    parameter int MIN_POS  = 0,
    parameter int MAX_POS  = 255,
    parameter int INIT_POS = 100
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [7:0] target,
    input  logic       target_valid,
    output logic       target_ready,
    input  logic [3:0] rate,
    output logic [7:0] pos,
    output logic       busy,
    output logic       done
);

    localparam int              CNT_W   = (CLK_DIV > 2) ? $clog2(CLK_DIV) : 1;
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(CLK_DIV - 1);
    localparam logic [7:0]      MIN_P   = 8'(MIN_POS);
    localparam logic [7:0]      MAX_P   = 8'(MAX_POS);
    localparam logic [7:0]      INIT_P  = 8'(INIT_POS);

    typedef enum logic {S_IDLE, S_RAMP} state_t;

    state_t           r_state;
    logic [CNT_W-1:0] r_cnt;
    logic [7:0]       r_pos;
    logic [7:0]       r_tgt;
    logic [3:0]       r_rate;
    logic             r_ready;
    logic             r_busy;
    logic             r_done;

    logic             w_tick;
    logic             w_accept;
    logic [7:0]       w_clamped;
    logic             w_up;
    logic [8:0]       w_diff;
    logic [7:0]       w_step_pos;

    assign w_tick   = (r_cnt == CNT_MAX);
    assign w_accept = target_valid & r_ready;

    assign w_clamped = (target < MIN_P) ? MIN_P :
                       (target > MAX_P) ? MAX_P : target;

    // Distance is taken 9-bit so the final step lands exactly on target
    // instead of overshooting or wrapping through 0/255.
    assign w_up       = (r_tgt > r_pos);
    assign w_diff     = w_up ? ({1'b0, r_tgt} - {1'b0, r_pos})
                             : ({1'b0, r_pos} - {1'b0, r_tgt});
    assign w_step_pos = (w_diff <= {5'b0, r_rate}) ? r_tgt :
                        w_up ? (r_pos + {4'b0, r_rate}) : (r_pos - {4'b0, r_rate});

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
            r_cnt   <= '0;
            r_pos   <= INIT_P;
            r_tgt   <= INIT_P;
            r_rate  <= '0;
            r_ready <= 1'b0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
        end else begin
            r_ready <= 1'b1;
            r_done  <= 1'b0;
            r_cnt   <= w_tick ? '0 : r_cnt + CNT_W'(1);
            // An accept always wins over a coincident tick; no step that cycle.
            if (w_accept) begin
                r_tgt   <= w_clamped;
                r_rate  <= rate;
                r_state <= S_RAMP;
                r_busy  <= 1'b1;
                if (rate == 4'd0) begin
                    r_pos <= w_clamped;
                end
            end else if (r_state == S_RAMP) begin
                if (r_pos == r_tgt) begin
                    r_state <= S_IDLE;
                    r_busy  <= 1'b0;
                    r_done  <= 1'b1;
                end else if (w_tick && (r_rate != 4'd0)) begin
                    r_pos <= w_step_pos;
                end
            end
        end
    end

    assign target_ready = r_ready;
    assign pos          = r_pos;
    assign busy         = r_busy;
    assign done         = r_done;

endmodule

// File: tb/tb_servo_ramp.sv
// Bench for servo_ramp: stimulus pushes expected pos/done events into a queue,
// an independent monitor pops and checks them as the DUT produces them.
module tb_servo_ramp;

    logic       clk;
    logic       rst_n;
    logic [7:0] target;
    logic       target_valid;
    logic       target_ready;
    logic [3:0] rate;
    logic [7:0] pos;
    logic       busy;
    logic       done;

    servo_ramp #(
        .CLK_DIV (4),
        .MIN_POS (10),
        .MAX_POS (200),
        .INIT_POS(100)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .target      (target),
        .target_valid(target_valid),
        .target_ready(target_ready),
        .rate        (rate),
        .pos         (pos),
        .busy        (busy),
        .done        (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        bit         is_done;
        logic [7:0] val;
        bit         busy;
        int         gap;
    } ev_t;

    ev_t        q[$];
    int         total = 0;
    int         bad   = 0;
    bit         mon_en = 0;
    logic [7:0] prev_pos;
    int         cyc = 0;
    int         last_cyc = 0;
    int         m_cnt = 0;

    // Reference tick phase: free-running 0..3, cleared by reset.
    always @(posedge clk) begin
        if (!rst_n) m_cnt <= 0;
        else        m_cnt <= (m_cnt == 3) ? 0 : m_cnt + 1;
    end

    always @(negedge clk) begin
        if (mon_en) begin
            ev_t e;
            cyc++;
            if (pos !== prev_pos) begin
                total++;
                if (q.size() == 0) begin
                    bad++;
                    $display("FAIL unexpected_pos: got pos=%0d, queue empty", pos);
                end else begin
                    e = q.pop_front();
                    if (e.is_done || e.val !== pos || e.busy !== busy ||
                        (e.gap != 0 && (cyc - last_cyc) != e.gap)) begin
                        bad++;
                        $display("FAIL pos_event: got pos=%0d busy=%0b gap=%0d, want done=%0b val=%0d busy=%0b gap=%0d",
                                 pos, busy, cyc - last_cyc, e.is_done, e.val, e.busy, e.gap);
                    end
                end
                last_cyc = cyc;
                prev_pos = pos;
            end
            if (done === 1'b1) begin
                total++;
                if (q.size() == 0) begin
                    bad++;
                    $display("FAIL unexpected_done: got done at pos=%0d, queue empty", pos);
                end else begin
                    e = q.pop_front();
                    if (!e.is_done || e.val !== pos || busy !== 1'b0) begin
                        bad++;
                        $display("FAIL done_event: got done pos=%0d busy=%0b, want done=%0b val=%0d busy=0",
                                 pos, busy, e.is_done, e.val);
                    end
                end
            end
        end
    end

    function automatic void push_pos(input logic [7:0] v, input bit b, input int g);
        ev_t e;
        e.is_done = 0; e.val = v; e.busy = b; e.gap = g;
        q.push_back(e);
    endfunction

    function automatic void push_done(input logic [7:0] v);
        ev_t e;
        e.is_done = 1; e.val = v; e.busy = 0; e.gap = 0;
        q.push_back(e);
    endfunction

    task automatic check(input string name, input logic [7:0] got, input logic [7:0] want);
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL %s: got %0d want %0d", name, got, want);
        end
    endtask

    // Called at a negedge; the accept happens on the following posedge and
    // the task returns at the negedge right after it.
    task automatic accept(input logic [7:0] t, input logic [3:0] r);
        target       = t;
        rate         = r;
        target_valid = 1'b1;
        @(negedge clk);
        target_valid = 1'b0;
    endtask

    task automatic drain(input string name);
        int n;
        n = 0;
        while (q.size() != 0 && n < 300) begin
            @(negedge clk);
            n++;
        end
        total++;
        if (q.size() != 0) begin
            bad++;
            $display("FAIL %s_drain: got %0d events outstanding want 0", name, q.size());
            q.delete();
        end
        repeat (8) @(negedge clk);
    endtask

    task automatic wait_pos(input string name, input logic [7:0] v);
        int n;
        n = 0;
        while (pos !== v && n < 300) begin
            @(negedge clk);
            n++;
        end
        if (pos !== v) begin
            total++;
            bad++;
            $display("FAIL %s_timeout: got pos=%0d want %0d", name, pos, v);
        end
    endtask

    initial begin
        rst_n        = 1'b0;
        target       = 8'd0;
        target_valid = 1'b0;
        rate         = 4'd0;

        // 1. reset
        repeat (3) @(negedge clk);
        check("rst_pos", pos, 8'd100);
        check("rst_busy", {7'b0, busy}, 8'd0);
        check("rst_done", {7'b0, done}, 8'd0);
        check("rst_ready", {7'b0, target_ready}, 8'd0);
        rst_n = 1'b1;
        @(negedge clk);
        check("ready_after_release", {7'b0, target_ready}, 8'd1);
        prev_pos = pos;
        mon_en   = 1;
        repeat (2) @(negedge clk);

        // 2. 100 -> 110 at rate 2, one step per tick
        push_pos(8'd102, 1, 0);
        for (int v = 104; v <= 110; v += 2) push_pos(8'(v), 1, 4);
        push_done(8'd110);
        accept(8'd110, 4'd2);
        check("busy_after_accept", {7'b0, busy}, 8'd1);
        drain("ramp_up");

        // jump back to 100
        push_pos(8'd100, 1, 0);
        push_done(8'd100);
        accept(8'd100, 4'd0);
        drain("jump_100");

        // 3. no overshoot: 100 -> 105 at rate 4
        push_pos(8'd104, 1, 0);
        push_pos(8'd105, 1, 4);
        push_done(8'd105);
        accept(8'd105, 4'd4);
        drain("no_overshoot");

        // 4. clamp high then jump to clamped low
        push_pos(8'd120, 1, 0);
        for (int v = 135; v <= 195; v += 15) push_pos(8'(v), 1, 4);
        push_pos(8'd200, 1, 4);
        push_done(8'd200);
        accept(8'd250, 4'd15);
        drain("clamp_high");
        push_pos(8'd10, 1, 0);
        push_done(8'd10);
        accept(8'd0, 4'd0);
        check("jump_low_pos", pos, 8'd10);
        check("jump_low_nodone", {7'b0, done}, 8'd0);
        @(negedge clk);
        check("jump_low_done", {7'b0, done}, 8'd1);
        drain("clamp_low");

        // 5. retarget 100 -> 150, redirected to 110 at 120
        push_pos(8'd100, 1, 0);
        push_done(8'd100);
        accept(8'd100, 4'd0);
        drain("jump_100b");
        push_pos(8'd101, 1, 0);
        for (int v = 102; v <= 120; v++) push_pos(8'(v), 1, 4);
        accept(8'd150, 4'd1);
        wait_pos("retarget", 8'd120);
        for (int v = 119; v >= 110; v--) push_pos(8'(v), 1, 4);
        push_done(8'd110);
        accept(8'd110, 4'd1);
        drain("retarget");

        // accept landing on a tick must not step in that cycle
        begin : tick_align
            int n;
            n = 0;
            while (m_cnt != 3 && n < 10) begin
                @(negedge clk);
                n++;
            end
        end
        push_pos(8'd105, 1, 0);
        push_pos(8'd100, 1, 4);
        push_done(8'd100);
        accept(8'd100, 4'd5);
        check("tick_accept_pos", pos, 8'd110);
        check("tick_accept_busy", {7'b0, busy}, 8'd1);
        drain("tick_accept");

        // 6. reset mid-ramp at 130
        push_pos(8'd110, 1, 0);
        push_pos(8'd120, 1, 4);
        push_pos(8'd130, 1, 4);
        accept(8'd200, 4'd10);
        wait_pos("mid_reset", 8'd130);
        push_pos(8'd100, 0, 0);
        rst_n = 1'b0;
        @(negedge clk);
        check("mid_reset_pos", pos, 8'd100);
        check("mid_reset_busy", {7'b0, busy}, 8'd0);
        check("mid_reset_ready", {7'b0, target_ready}, 8'd0);
        rst_n = 1'b1;
        @(negedge clk);
        check("mid_reset_ready_back", {7'b0, target_ready}, 8'd1);
        repeat (6) @(negedge clk);
        check("mid_reset_idle", {7'b0, busy}, 8'd0);
        push_pos(8'd102, 1, 0);
        push_pos(8'd104, 1, 4);
        push_done(8'd104);
        accept(8'd104, 4'd2);
        drain("after_reset");

        mon_en = 0;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
